// File: rtl/stream_mux_pkg.sv
// Shared types and limits for the round-robin stream multiplexer.
package stream_mux_pkg;

  // Source selection policy for the mux.
  typedef enum logic {
    MODE_RR    = 1'b0,
    MODE_FIXED = 1'b1
  } mode_t;

  // Largest supported channel count.
  localparam int MAX_N = 16;

endpackage : stream_mux_pkg

// File: rtl/rr_arbiter_n.sv
// Combinational rotating-priority arbiter.
// Priority starts at channel ptr+1 and wraps modulo N.
// The caller must keep ptr below N.
module rr_arbiter_n #(
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_any
);

  // One extra bit, because ptr + offset can reach 2N-1 before it wraps.
  logic [SEL_W:0] pos;

  // Scan the offsets from farthest to nearest. A later hit overwrites an
  // earlier one, so the channel nearest to ptr+1 ends up winning.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    pos     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (SEL_W+1)'(N - k);
      if (pos >= (SEL_W+1)'(N)) begin
        pos = pos - (SEL_W+1)'(N);
      end
      if (req[pos[SEL_W-1:0]]) begin
        gnt_idx = pos[SEL_W-1:0];
        gnt_any = 1'b1;
      end
    end
    gnt[gnt_idx] = gnt_any;
  end

endmodule : rr_arbiter_n

// File: rtl/stream_mux_rr.sv
// N-channel registered stream multiplexer with valid/ready handshakes.
// The source is chosen by round-robin arbitration or by a fixed select.
// Optional packet locking is enabled with macro STREAM_MUX_LAST_EN. It adds
// the in_last/out_last ports and holds the grant until a packet completes.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic [N-1:0]     in_valid,
  input  logic [N*W-1:0]   in_data,
  output logic [N-1:0]     in_ready,
`ifdef STREAM_MUX_LAST_EN
  input  logic [N-1:0]     in_last,
  output logic             out_last,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_ch
);

  mode_t            mode_m;
  logic [SEL_W-1:0] ptr_q;
  logic [N-1:0]     rr_gnt;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_any;
  logic             sel_ok;
  logic [N-1:0]     grant;
  logic [SEL_W-1:0] grant_idx;
  logic             grant_any;
  logic             load_ok;
  logic             xfer;
`ifdef STREAM_MUX_LAST_EN
  logic             lock_q;
  logic [SEL_W-1:0] lock_ch_q;
`endif

  assign mode_m  = mode_t'(mode);
  assign sel_ok  = (32'(sel) < N);
  assign load_ok = !out_valid || out_ready;

  rr_arbiter_n #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_arb (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  // Pick the winning channel. A packet lock overrides both modes.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
`ifdef STREAM_MUX_LAST_EN
    if (lock_q) begin
      grant_idx        = lock_ch_q;
      grant_any        = in_valid[lock_ch_q];
      grant[lock_ch_q] = in_valid[lock_ch_q];
    end else
`endif
    if (mode_m == MODE_RR) begin
      grant     = rr_gnt;
      grant_idx = rr_idx;
      grant_any = rr_any;
    end else if (sel_ok) begin
      grant_idx  = sel;
      grant_any  = in_valid[sel];
      grant[sel] = in_valid[sel];
    end
  end

  // No channel is granted while reset is asserted.
  // A beat transfers only when the output register can accept it.
  always_comb begin
    in_ready = '0;
    xfer     = 1'b0;
    if (rst && load_ok) begin
      in_ready = grant;
      xfer     = grant_any;
    end
  end

  // Output register, round-robin pointer and packet lock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr_q     <= SEL_W'(N - 1);
`ifdef STREAM_MUX_LAST_EN
      out_last  <= 1'b0;
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
`endif
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= in_data[grant_idx*W +: W];
        out_ch    <= grant_idx;
        if (mode_m == MODE_RR) begin
          ptr_q <= grant_idx;
        end
`ifdef STREAM_MUX_LAST_EN
        out_last  <= in_last[grant_idx];
        lock_q    <= !in_last[grant_idx];
        lock_ch_q <= grant_idx;
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule : stream_mux_rr

// File: tb/tb_stream_mux_rr.sv
// Directed, table-driven testbench for stream_mux_rr with N=4 and W=4.
module tb_stream_mux_rr;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mode = 1'b0;
  logic [1:0] sel = '0;
  logic [3:0] in_valid = '0;
  logic [15:0] in_data = {4'hD, 4'hC, 4'hB, 4'hA};
  logic [3:0] in_ready;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_data;
  logic [1:0] out_ch;
`ifdef STREAM_MUX_LAST_EN
  logic [3:0] in_last = 4'hF;
  logic       out_last;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] iv;
    logic       ordy;
    logic [3:0] ir;
    logic       ov;
    logic [3:0] od;
    logic [1:0] och;
  } vec_t;

  vec_t vecs[27];

  stream_mux_rr #(.N(4), .W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
`ifdef STREAM_MUX_LAST_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //            mode  sel   iv     ordy  ir       ov    od     och
    vecs[0]  = '{1'b0, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 4'hA, 2'd0};
    vecs[1]  = '{1'b0, 2'd0, 4'hF, 1'b1, 4'b0010, 1'b1, 4'hB, 2'd1};
    vecs[2]  = '{1'b0, 2'd0, 4'hF, 1'b1, 4'b0100, 1'b1, 4'hC, 2'd2};
    vecs[3]  = '{1'b0, 2'd0, 4'hF, 1'b1, 4'b1000, 1'b1, 4'hD, 2'd3};
    vecs[4]  = '{1'b0, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 4'hA, 2'd0};
    vecs[5]  = '{1'b0, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 4'hA, 2'd0};
    vecs[6]  = '{1'b0, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 4'hA, 2'd0};
    vecs[7]  = '{1'b0, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 4'hA, 2'd0};
    vecs[8]  = '{1'b0, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 4'hA, 2'd0};
    vecs[9]  = '{1'b0, 2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 4'hA, 2'd0};
    vecs[10] = '{1'b0, 2'd0, 4'hF, 1'b1, 4'b0010, 1'b1, 4'hB, 2'd1};
    vecs[11] = '{1'b0, 2'd0, 4'hF, 1'b1, 4'b0100, 1'b1, 4'hC, 2'd2};
    vecs[12] = '{1'b1, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 4'hC, 2'd2};
    vecs[13] = '{1'b1, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 4'hC, 2'd2};
    vecs[14] = '{1'b1, 2'd2, 4'hB, 1'b1, 4'b0000, 1'b0, 4'hC, 2'd2};
    vecs[15] = '{1'b1, 2'd2, 4'hB, 1'b1, 4'b0000, 1'b0, 4'hC, 2'd2};
    vecs[16] = '{1'b0, 2'd0, 4'h8, 1'b1, 4'b1000, 1'b1, 4'hD, 2'd3};
    vecs[17] = '{1'b0, 2'd0, 4'h4, 1'b1, 4'b0100, 1'b1, 4'hC, 2'd2};
    vecs[18] = '{1'b0, 2'd0, 4'h9, 1'b1, 4'b1000, 1'b1, 4'hD, 2'd3};
    vecs[19] = '{1'b0, 2'd0, 4'h9, 1'b1, 4'b0001, 1'b1, 4'hA, 2'd0};
    vecs[20] = '{1'b1, 2'd1, 4'hF, 1'b0, 4'b0000, 1'b1, 4'hA, 2'd0};
    vecs[21] = '{1'b1, 2'd1, 4'hF, 1'b1, 4'b0010, 1'b1, 4'hB, 2'd1};
    vecs[22] = '{1'b0, 2'd0, 4'hF, 1'b1, 4'b0010, 1'b1, 4'hB, 2'd1};
    vecs[23] = '{1'b0, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b0, 4'hB, 2'd1};
    vecs[24] = '{1'b0, 2'd0, 4'h0, 1'b0, 4'b0000, 1'b0, 4'hB, 2'd1};
    vecs[25] = '{1'b0, 2'd0, 4'h1, 1'b0, 4'b0001, 1'b1, 4'hA, 2'd0};
    vecs[26] = '{1'b0, 2'd0, 4'hF, 1'b1, 4'b0010, 1'b1, 4'hB, 2'd1};

    // Reset held for three cycles with random control inputs.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mode      = 1'($urandom);
      sel       = 2'($urandom);
      in_valid  = 4'($urandom);
      out_ready = 1'($urandom);
      #1;
      chk($sformatf("rst%0d_in_ready", i), 32'(in_ready), 32'h0);
      @(posedge clk); #1;
      chk($sformatf("rst%0d_out_valid", i), 32'(out_valid), 32'h0);
      chk($sformatf("rst%0d_out_data", i), 32'(out_data), 32'h0);
      chk($sformatf("rst%0d_out_ch", i), 32'(out_ch), 32'h0);
    end
    rst = 1'b1;

    // Apply the vector table, one cycle per entry.
    for (int v = 0; v < 27; v++) begin
      @(negedge clk);
      mode      = vecs[v].mode;
      sel       = vecs[v].sel;
      in_valid  = vecs[v].iv;
      out_ready = vecs[v].ordy;
      #1;
      chk($sformatf("v%0d_in_ready", v), 32'(in_ready), 32'(vecs[v].ir));
      @(posedge clk); #1;
      chk($sformatf("v%0d_out_valid", v), 32'(out_valid), 32'(vecs[v].ov));
      chk($sformatf("v%0d_out_data", v), 32'(out_data), 32'(vecs[v].od));
      chk($sformatf("v%0d_out_ch", v), 32'(out_ch), 32'(vecs[v].och));
    end

    // Asserting reset mid-operation discards the held beat at once.
    @(negedge clk);
    mode      = 1'b0;
    in_valid  = 4'hF;
    out_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'h0);
    chk("midrst_out_data", 32'(out_data), 32'h0);
    chk("midrst_out_ch", 32'(out_ch), 32'h0);
    chk("midrst_in_ready", 32'(in_ready), 32'h0);
    @(negedge clk);
    rst       = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("postrst_in_ready", 32'(in_ready), 32'b0001);
    @(posedge clk); #1;
    chk("postrst_out_valid", 32'(out_valid), 32'h1);
    chk("postrst_out_data", 32'(out_data), 32'hA);
    chk("postrst_out_ch", 32'(out_ch), 32'h0);

`ifdef STREAM_MUX_LAST_EN
    // Three-beat packet on ch1 while ch0 and ch2 stay valid. ptr is now 0.
    begin
      logic [3:0] lasts [4];
      logic [3:0] exp_ir [4];
      logic [1:0] exp_ch [4];
      logic [3:0] exp_od [4];
      logic       exp_last [4];
      lasts    = '{4'b1101, 4'b1101, 4'b1111, 4'b1111};
      exp_ir   = '{4'b0010, 4'b0010, 4'b0010, 4'b0100};
      exp_ch   = '{2'd1, 2'd1, 2'd1, 2'd2};
      exp_od   = '{4'hB, 4'hB, 4'hB, 4'hC};
      exp_last = '{1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        mode      = 1'b0;
        in_valid  = 4'b0111;
        out_ready = 1'b1;
        in_last   = lasts[i];
        #1;
        chk($sformatf("pkt%0d_in_ready", i), 32'(in_ready), 32'(exp_ir[i]));
        @(posedge clk); #1;
        chk($sformatf("pkt%0d_out_ch", i), 32'(out_ch), 32'(exp_ch[i]));
        chk($sformatf("pkt%0d_out_data", i), 32'(out_data), 32'(exp_od[i]));
        chk($sformatf("pkt%0d_out_last", i), 32'(out_last), 32'(exp_last[i]));
      end
    end
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_stream_mux_rr

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- N-channel, W-bit-wide stream multiplexer with valid/ready handshakes on every input and on the single output.
- Selects the source either by round-robin arbitration or by a fixed external select.
- The output is registered: 1-cycle latency, full throughput of 1 beat/cycle.
- Generalises the 2:1/4:1 combinational mux into the datapath stage placed in front of shared sinks (FIFOs, output formatters).

Parameters:
- N, 4, number of input channels (2..16).
- W, 4, data width per channel.
- SEL_W, $clog2(N), width of sel and out_ch (derived; do not override).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-low (asserted when 0).
- mode  input  1  0 = round-robin, 1 = fixed select.
- sel  input  SEL_W  channel index used when mode = 1.
- in_valid  input  N  per-channel valid.
- in_data  input  N*W  flattened; channel i occupies bits [i*W +: W].
- in_ready  output  N  per-channel ready (combinational).
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.
- out_data  output  W  registered output data.
- out_ch  output  SEL_W  index of the channel that produced out_data.

Behaviour:
- Reset (rst = 0, async):
  - out_valid = 0, out_data = 0, out_ch = 0.
  - Round-robin pointer ptr = N-1, so channel 0 has first priority.
- Output register can load when load_ok = !out_valid || out_ready.
- Arbitration (combinational, evaluated every cycle):
  - mode 0: grant the first channel with in_valid = 1, searching ptr+1, ptr+2, … with modulo-N wrap.
  - mode 1: grant channel sel only if in_valid[sel] = 1.
  - mode 1, sel >= N (non-power-of-2 N): no grant; nothing transfers.
  - No valid channel: no grant.
- in_ready[i] = grant[i] && load_ok. At most one in_ready bit is high; in_ready never depends on in_valid of other channels in mode 1.
- Transfer on channel g (in_valid[g] && in_ready[g]):
  - Next cycle: out_valid = 1, out_data = in_data[g], out_ch = g.
  - In mode 0, ptr <= g. In mode 1, ptr is unchanged.
- Output handshake:
  - out_valid && out_ready with no new transfer: out_valid <= 0; out_data and out_ch hold their last values.
  - Simultaneous output pop and input push in the same cycle: the register reloads and out_valid stays 1 (back-to-back, no bubble).
- Stall: out_valid = 1 && out_ready = 0:
  - all in_ready = 0;
  - out_data and out_ch stable;
  - ptr frozen.
- Mode/sel changes take effect in the same cycle's arbitration; a beat already held in the output register is unaffected.
- Reset mid-operation: a held beat is discarded; no partial state survives.
- Round-robin fairness: with all N channels continuously valid and out_ready = 1, each channel is granted exactly once per N consecutive beats.

Optional Feature:
- Macro: STREAM_MUX_LAST_EN.
- Defined:
  - Adds in_last (input, N) and out_last (output, 1, registered with data; reset 0).
  - After a transfer with in_last[g] = 0, the grant is locked to g (in both modes) until a beat with in_last[g] = 1 transfers. Packets are never interleaved.
  - The lock is cleared by reset.
- Undefined:
  - No last ports exist.
  - Every beat is arbitrated independently as above.

Decomposition:
- Package stream_mux_pkg:
  - typedef enum logic {MODE_RR = 1'b0, MODE_FIXED = 1'b1} mode_t;
  - localparam MAX_N = 16.
- Sub-module rr_arbiter_n (parameter N):
  - inputs: req[N], ptr[SEL_W];
  - outputs: one-hot gnt[N], gnt_idx, gnt_any;
  - purely combinational rotate-priority-unrotate.
- Pointer, lock and output register stay in stream_mux_rr.

Test Plan:
- Reset: hold rst = 0 for 3 cycles with random inputs -> out_valid = 0, out_data = 0, out_ch = 0, all in_ready = 0 because there is no grant until rst releases.
- RR fairness: N = 4, W = 4, mode = 0, all in_valid = 1, in_data = {4'hD, 4'hC, 4'hB, 4'hA}, out_ready = 1 -> out_ch sequence 0, 1, 2, 3, 0…; out_data A, B, C, D, A…; first out_valid one cycle after rst release.
- Backpressure: as above, out_ready = 0 for 5 cycles after the first beat -> out_data = A held for 5 cycles, in_ready = 0000 throughout; releasing out_ready resumes with channel 1, no beat lost or duplicated.
- Fixed select: mode = 1, sel = 2, in_valid = 1111 -> only in_ready[2] ever high; out_ch = 2 every cycle. Then in_valid[2] = 0 -> out_valid drops after one cycle.
- Wrap and skip: mode = 0, ptr = 3 after a beat on ch3, in_valid = 0100 -> next grant is ch2 (wrap 0 -> 1 -> 2); then in_valid = 1001 -> grant ch3, then ch0.
- With STREAM_MUX_LAST_EN: ch1 sends 3 beats, last on beat 3, while ch0 and ch2 are valid -> out_ch = 1, 1, 1 contiguous with out_last = 0, 0, 1; next grant goes to ch2.
